mc_control_fsm: RTL and testbench

Multicycle control sequencer for the MIPS-subset processor datapath (PC, IR, register file, ALU, unified memory). It decodes opcode/funct from the IR and steps the shared datapath through fetch, decode, execute, memory and writeback, one state per clock. It handshakes with memory via mem_req/mem_ready and keeps a retired-instruction counter for the self-checking processor bench.

---
 rtl/mc_ctrl_pkg.sv | 74 +++++++
 rtl/mc_alu_decode.sv | 74 +++++++
 rtl/mc_control_fsm.sv | 210 +++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset control path. The
// datapath and the bench use the same state, opcode and mux encodings.
package mc_ctrl_pkg;

    // Controller states; the encodings are visible on state_dbg.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_REX    = 4'd6,
        S_RWB    = 4'd7,
        S_IEX    = 4'd8,
        S_IWB    = 4'd9,
        S_BEQ    = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    // Selects how the ALU decoder derives alu_ctrl/ext_zero in a given state.
    typedef enum logic [2:0] {
        CLS_NONE  = 3'd0,  // ALU unused; outputs parked at 0
        CLS_ADD   = 3'd1,  // PC+4, branch target, load/store address
        CLS_SUB   = 3'd2,  // beq compare
        CLS_RTYPE = 3'd3,  // operation chosen by funct
        CLS_IMM   = 3'd4   // operation and extension chosen by opcode
    } alu_class_t;

    // Opcodes (IR[31:26]).
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_NORI  = 6'b001110;

    // R-type function codes (IR[5:0]).
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // ALU operation codes.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU B-operand mux.
    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    // PC source mux.
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // True for the R-type function codes the datapath implements.
    function automatic logic funct_legal(input logic [5:0] funct);
        return funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_NOR};
    endfunction

endpackage

// File: rtl/mc_alu_decode.sv
// Combinational ALU decoder: maps the current state class plus opcode/funct
// onto alu_ctrl and the immediate-extension mode, and flags whether the
// instruction is one the datapath supports.
module mc_alu_decode
    import mc_ctrl_pkg::*;
#(
    parameter logic [5:0] NORI_OP = OP_NORI
) (
    input  alu_class_t  alu_class,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [3:0]  alu_ctrl,
    output logic        ext_zero,
    output logic        legal
);

    logic is_imm;

    // Supported-instruction check, independent of the current state.
    always_comb begin
        is_imm = (opcode inside {OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI}) || (opcode == NORI_OP);
        if (opcode == OP_RTYPE) begin
            legal = funct_legal(funct);
        end else begin
            legal = is_imm || (opcode inside {OP_LW, OP_SW, OP_BEQ, OP_J});
        end
    end

    // ALU operation and immediate extension for the current state class.
    always_comb begin
        // NOTE: every output gets a default first so no path through the
        // case statements can leave one unassigned and infer a latch.
        alu_ctrl = ALU_AND;
        ext_zero = 1'b0;
        case (alu_class)
            CLS_ADD: alu_ctrl = ALU_ADD;
            CLS_SUB: alu_ctrl = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    FN_NOR:  alu_ctrl = ALU_NOR;
                    default: alu_ctrl = ALU_AND;
                endcase
            end
            CLS_IMM: begin
                // nori's opcode is a parameter, so it is matched outside the case.
                if (opcode == NORI_OP) begin
                    alu_ctrl = ALU_NOR;
                    ext_zero = 1'b1;
                end else begin
                    case (opcode)
                        OP_ADDI: alu_ctrl = ALU_ADD;
                        OP_ANDI: begin
                            alu_ctrl = ALU_AND;
                            ext_zero = 1'b1;
                        end
                        OP_ORI: begin
                            alu_ctrl = ALU_OR;
                            ext_zero = 1'b1;
                        end
                        OP_SLTI: alu_ctrl = ALU_SLT;
                        default: alu_ctrl = ALU_AND;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle control sequencer: steps the shared datapath through fetch,
// decode, execute, memory and writeback one state per clock, handshakes
// with memory and counts retired instructions.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] NORI_OP = 6'b001110
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_write,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic             ext_zero,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state_dbg
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_count_q, instr_count_d;
    alu_class_t       alu_class;
    logic             legal;

    mc_alu_decode #(
        .NORI_OP (NORI_OP)
    ) u_alu_decode (
        .alu_class (alu_class),
        .opcode    (opcode),
        .funct     (funct),
        .alu_ctrl  (alu_ctrl),
        .ext_zero  (ext_zero),
        .legal     (legal)
    );

    // Next-state and control outputs; reset overrides every strobe.
    always_comb begin
        state_d    = state_q;
        alu_class  = CLS_NONE;
        mem_req    = 1'b0;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        pc_src     = PCSRC_ALU;
        instr_done = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_class = CLS_ADD;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here while the opcode decodes.
                alu_src_b = SRCB_IMM_SH;
                alu_class = CLS_ADD;
                if (!legal) begin
                    // Unsupported instructions retire as a nop.
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_REX;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BEQ;
                end else if (opcode == OP_J) begin
                    state_d = S_JMP;
                end else begin
                    state_d = S_IEX;
                end
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_class = CLS_ADD;
                state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_REX: begin
                alu_src_a = 1'b1;
                alu_class = CLS_RTYPE;
                state_d   = S_RWB;
            end
            S_RWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_IEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_class = CLS_IMM;
                state_d   = S_IWB;
            end
            S_IWB: begin
                // Same class as IEX keeps ext_zero stable through writeback.
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_class  = CLS_IMM;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a  = 1'b1;
                alu_class  = CLS_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_write   = zero;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JMP: begin
                pc_src     = PCSRC_JUMP;
                pc_write   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (reset) begin
            state_d    = S_FETCH;
            alu_class  = CLS_NONE;
            mem_req    = 1'b0;
            pc_write   = 1'b0;
            iord       = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_RT;
            pc_src     = PCSRC_ALU;
            instr_done = 1'b0;
            illegal_op = 1'b0;
        end
    end

    // Retired-instruction counter advances on the instr_done edge and wraps.
    always_comb begin
        instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, instr_done};
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q       <= S_FETCH;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign instr_count = instr_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: walks each instruction class cycle by
// cycle against hand-derived control values.
module tb_mc_control_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, pc_write, iord, mem_write, ir_write;
    logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0]  alu_src_b, pc_src;
    logic [3:0]  alu_ctrl;
    logic        ext_zero, instr_done, illegal_op;
    logic [31:0] instr_count;
    logic [3:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    mc_control_fsm dut (
        .clk         (clk),
        .reset       (reset),
        .opcode      (opcode),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .pc_write    (pc_write),
        .iord        (iord),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_ctrl    (alu_ctrl),
        .pc_src      (pc_src),
        .ext_zero    (ext_zero),
        .instr_done  (instr_done),
        .illegal_op  (illegal_op),
        .instr_count (instr_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are then set, and checks
    // follow a further #1 so outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        mem_ready = 1'b1;
        zero      = 1'b0;
        opcode    = 6'b000000;
        funct     = 6'b100000;   // add

        // Reset held for two edges with mem_ready high.
        tick();
        tick();
        settle();
        check("rst_state", state_dbg, 0);
        check("rst_count", instr_count, 0);
        check("rst_ir_write", ir_write, 0);
        check("rst_pc_write", pc_write, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_reg_write", reg_write, 0);
        check("rst_done", instr_done, 0);

        // ---- add: FETCH, DECODE, REX, RWB ----
        reset = 1'b0;
        settle();
        check("add_fetch_state", state_dbg, 0);
        check("add_fetch_ir_write", ir_write, 1);
        check("add_fetch_pc_write", pc_write, 1);
        check("add_fetch_mem_req", mem_req, 1);
        check("add_fetch_srcb", alu_src_b, 1);
        check("add_fetch_alu", alu_ctrl, 4'b0010);
        tick(); settle();
        check("add_dec_state", state_dbg, 1);
        check("add_dec_srcb", alu_src_b, 3);
        check("add_dec_illegal", illegal_op, 0);
        tick(); settle();
        check("add_rex_state", state_dbg, 6);
        check("add_rex_alu", alu_ctrl, 4'b0010);
        check("add_rex_srca", alu_src_a, 1);
        check("add_rex_srcb", alu_src_b, 0);
        tick(); settle();
        check("add_rwb_state", state_dbg, 7);
        check("add_rwb_reg_write", reg_write, 1);
        check("add_rwb_reg_dst", reg_dst, 1);
        check("add_rwb_done", instr_done, 1);
        tick(); settle();
        check("add_count", instr_count, 1);
        check("add_back_fetch", state_dbg, 0);

        // ---- lw with three wait cycles in MEMRD ----
        opcode = 6'b100011;
        settle();
        tick(); settle();
        check("lw_dec_state", state_dbg, 1);
        tick(); settle();
        check("lw_memadr_state", state_dbg, 2);
        check("lw_memadr_srcb", alu_src_b, 2);
        check("lw_memadr_ext", ext_zero, 0);
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("lw_wait%0d_state", i), state_dbg, 3);
            check($sformatf("lw_wait%0d_req", i), mem_req, 1);
            check($sformatf("lw_wait%0d_iord", i), iord, 1);
            tick();
        end
        mem_ready = 1'b1;
        settle();
        check("lw_memrd_ready_state", state_dbg, 3);
        tick(); settle();
        check("lw_memwb_state", state_dbg, 4);
        check("lw_memwb_m2r", mem_to_reg, 1);
        check("lw_memwb_reg_write", reg_write, 1);
        check("lw_memwb_reg_dst", reg_dst, 0);
        check("lw_memwb_done", instr_done, 1);
        tick(); settle();
        check("lw_count", instr_count, 2);

        // ---- beq taken then not taken ----
        opcode = 6'b000100;
        zero   = 1'b1;
        settle();
        tick(); tick(); settle();
        check("beq1_state", state_dbg, 10);
        check("beq1_pc_write", pc_write, 1);
        check("beq1_pc_src", pc_src, 1);
        check("beq1_alu", alu_ctrl, 4'b0110);
        check("beq1_done", instr_done, 1);
        tick(); settle();
        check("beq1_count", instr_count, 3);
        zero = 1'b0;
        tick(); tick(); settle();
        check("beq2_state", state_dbg, 10);
        check("beq2_pc_write", pc_write, 0);
        tick(); settle();
        check("beq2_count", instr_count, 4);

        // ---- nori ----
        opcode = 6'b001110;
        settle();
        tick(); tick(); settle();
        check("nori_iex_state", state_dbg, 8);
        check("nori_iex_alu", alu_ctrl, 4'b1100);
        check("nori_iex_ext", ext_zero, 1);
        check("nori_iex_srcb", alu_src_b, 2);
        tick(); settle();
        check("nori_iwb_state", state_dbg, 9);
        check("nori_iwb_alu", alu_ctrl, 4'b1100);
        check("nori_iwb_ext", ext_zero, 1);
        check("nori_iwb_reg_write", reg_write, 1);
        check("nori_iwb_reg_dst", reg_dst, 0);
        tick(); settle();
        check("nori_count", instr_count, 5);

        // ---- illegal opcode 111111 ----
        opcode = 6'b111111;
        settle();
        tick(); settle();
        check("ill_dec_state", state_dbg, 1);
        check("ill_dec_illegal", illegal_op, 1);
        check("ill_dec_done", instr_done, 1);
        tick(); settle();
        check("ill_back_fetch", state_dbg, 0);
        check("ill_pulse_off", illegal_op, 0);
        check("ill_count", instr_count, 6);

        // ---- R-type with unsupported funct takes the illegal path ----
        opcode = 6'b000000;
        funct  = 6'b000001;
        settle();
        tick(); settle();
        check("badfn_illegal", illegal_op, 1);
        tick(); settle();
        check("badfn_count", instr_count, 7);

        // ---- addi: sign-extended ----
        opcode = 6'b001000;
        settle();
        tick(); tick(); settle();
        check("addi_iex_alu", alu_ctrl, 4'b0010);
        check("addi_iex_ext", ext_zero, 0);
        tick(); tick(); settle();
        check("addi_count", instr_count, 8);

        // ---- j ----
        opcode = 6'b000010;
        settle();
        tick(); tick(); settle();
        check("j_state", state_dbg, 11);
        check("j_pc_src", pc_src, 2);
        check("j_pc_write", pc_write, 1);
        tick(); settle();
        check("j_count", instr_count, 9);

        // ---- sw: FETCH wait, then reset during MEMWR wait ----
        opcode    = 6'b101011;
        mem_ready = 1'b0;
        settle();
        check("sw_fetch_wait_req", mem_req, 1);
        check("sw_fetch_wait_ir", ir_write, 0);
        check("sw_fetch_wait_pc", pc_write, 0);
        tick();
        mem_ready = 1'b1;
        settle();
        check("sw_fetch_held", state_dbg, 0);
        tick(); tick(); tick();
        mem_ready = 1'b0;
        settle();
        check("sw_memwr_state", state_dbg, 5);
        check("sw_memwr_write", mem_write, 1);
        check("sw_memwr_req", mem_req, 1);
        check("sw_memwr_done", instr_done, 0);
        tick(); settle();
        check("sw_memwr_held", state_dbg, 5);
        reset = 1'b1;
        settle();
        check("sw_rst_write", mem_write, 0);
        check("sw_rst_req", mem_req, 0);
        tick(); settle();
        check("sw_rst_state", state_dbg, 0);
        check("sw_rst_count", instr_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
